// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the spram_b16_arbiter slice.
//   ARB_RR / ARB_FIXED : arbitration mode encodings for the ARB_MODE parameter
//   state_t            : sequencer state (zero-fill, then normal arbitration)
//   req_t              : one requester's command, sized for the default macro
package spram_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int SPRAM_ADDR_W = 8;
    localparam int SPRAM_DATA_W = 128;
    localparam int SPRAM_BE_W   = SPRAM_DATA_W / 8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic                    we;
        logic [SPRAM_ADDR_W-1:0] addr;
        logic [SPRAM_DATA_W-1:0] wdata;
        logic [SPRAM_BE_W-1:0]   strb;
    } req_t;

endpackage

// File: rtl/spram_b16_arbiter_if.sv
// Request channel of one arbiter port (valid/ready handshake).
//   master : requester side, drives the command and samples req_ready
//   slave  : arbiter side, samples the command and drives req_ready
interface spram_b16_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int BE_W   = DATA_W / 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_strb;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_strb,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_strb,
        output req_ready
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input grant logic, purely combinational.
//   req[1:0]   : eligible requesters
//   mode       : 0 = round-robin, 1 = fixed priority (port 0 wins ties)
//   last_grant : port granted most recently (round-robin only)
//   gnt[1:0]   : one-hot grant, zero when nothing is requested
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       mode,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        // On a tie, round-robin hands the slot to the port that did not win last.
        if (&req) gnt = (mode || last_grant) ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/spram_b16_arbiter.sv
// Two-port arbiter/sequencer in front of one 256x128 byte-lane single-port SRAM.
// After reset it optionally zero-fills the array, then grants at most one
// request per cycle and returns read data one cycle after the accept edge.
//   clk, rst        : clock, synchronous active-high reset
//   p0, p1          : request channels (slave modport)
//   rsp_valid/port  : read response valid and originating port
//   rsp_rdata       : read data, passed straight through from ram_q
//   init_done       : fill finished, requests are being accepted
//   ram_*           : SRAM macro pins (CEB/WEB/BWEB active low), ram_q return data
module spram_b16_arbiter
    import spram_arb_pkg::*;
#(
    parameter int ADDR_W   = SPRAM_ADDR_W,
    parameter int DATA_W   = SPRAM_DATA_W,
    parameter int BE_W     = DATA_W / 8,
    parameter int ARB_MODE = ARB_RR,
    parameter int INIT_EN  = 1
) (
    input  logic               clk,
    input  logic               rst,
    spram_b16_arbiter_if.slave p0,
    spram_b16_arbiter_if.slave p1,
    output logic               rsp_valid,
    output logic               rsp_port,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               init_done,
    output logic               ram_ceb,
    output logic               ram_web,
    output logic [ADDR_W-1:0]  ram_a,
    output logic [DATA_W-1:0]  ram_d,
    output logic [BE_W-1:0]    ram_bweb,
    input  logic [DATA_W-1:0]  ram_q
);
    localparam logic [ADDR_W-1:0] INIT_LAST = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic              last_grant;
    logic              rd_pend, rd_port;

    req_t [1:0]        req;
    logic [1:0]        vld, elig, noop, arb_req, gnt, rdy;
    logic              run, sel, any_gnt;

    always_comb begin
        req[0].we    = p0.req_we;
        req[0].addr  = p0.req_addr;
        req[0].wdata = p0.req_wdata;
        req[0].strb  = p0.req_strb;
        req[1].we    = p1.req_we;
        req[1].addr  = p1.req_addr;
        req[1].wdata = p1.req_wdata;
        req[1].strb  = p1.req_strb;
        vld          = {p1.req_valid, p0.req_valid};
        for (int i = 0; i < 2; i++) begin
            // A write with no byte enables is acknowledged but never reaches the SRAM.
            noop[i] = vld[i] & req[i].we & ~(|req[i].strb);
            elig[i] = vld[i] & ~noop[i];
        end
    end

    // rst gates the command outputs so the macro never sees a stray access
    // while the sequencer is being reset.
    assign run     = (state == ST_RUN) & ~rst;
    assign arb_req = run ? elig : 2'b00;

    rr_arb2 u_arb (
        .req        (arb_req),
        .mode       (ARB_MODE == ARB_FIXED),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign sel     = gnt[1];
    assign any_gnt = |gnt;

    always_comb begin
        state_nxt = state;
        rdy       = 2'b00;
        ram_ceb   = 1'b1;
        ram_web   = 1'b1;
        ram_a     = '0;
        ram_d     = '0;
        ram_bweb  = '0;
        if (!rst) begin
            if (state == ST_INIT) begin
                ram_ceb = 1'b0;
                ram_web = 1'b0;
                ram_a   = init_cnt;
                if (init_cnt == INIT_LAST) state_nxt = ST_RUN;
            end else begin
                rdy = gnt | noop;
                if (any_gnt) begin
                    ram_ceb = 1'b0;
                    ram_web = ~req[sel].we;
                    ram_a   = req[sel].addr;
                    if (req[sel].we) begin
                        ram_d    = req[sel].wdata;
                        ram_bweb = ~req[sel].strb;
                    end else begin
                        ram_bweb = '1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_cnt   <= '0;
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_port    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
            if (any_gnt) last_grant <= sel;
            rd_pend <= any_gnt & ~req[sel].we;
            if (any_gnt && !req[sel].we) rd_port <= sel;
        end
    end

    assign p0.req_ready = rdy[0];
    assign p1.req_ready = rdy[1];
    assign init_done    = (state == ST_RUN);
    // Masked by rst so a response caught by reset is never presented.
    assign rsp_valid    = rd_pend & ~rst;
    assign rsp_port     = rd_port;
    assign rsp_rdata    = ram_q;

endmodule

// File: tb/tb_spram_b16_arbiter.sv
module tb_spram_b16_arbiter;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [127:0] W  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] LO = 128'h00000000000000000706050403020100;
    localparam logic [127:0] Z  = 128'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         v0 = 0, we0 = 0, v1 = 0, we1 = 0;
    logic [7:0]   ad0 = 0, ad1 = 0;
    logic [15:0]  st0 = 0, st1 = 0;
    logic [127:0] wd = W;

    spram_b16_arbiter_if a0 ();
    spram_b16_arbiter_if a1 ();
    spram_b16_arbiter_if b0 ();
    spram_b16_arbiter_if b1 ();

    assign a0.req_valid = v0;  assign b0.req_valid = v0;
    assign a0.req_we    = we0; assign b0.req_we    = we0;
    assign a0.req_addr  = ad0; assign b0.req_addr  = ad0;
    assign a0.req_wdata = wd;  assign b0.req_wdata = wd;
    assign a0.req_strb  = st0; assign b0.req_strb  = st0;
    assign a1.req_valid = v1;  assign b1.req_valid = v1;
    assign a1.req_we    = we1; assign b1.req_we    = we1;
    assign a1.req_addr  = ad1; assign b1.req_addr  = ad1;
    assign a1.req_wdata = wd;  assign b1.req_wdata = wd;
    assign a1.req_strb  = st1; assign b1.req_strb  = st1;

    // dut0: round-robin with fill; dut1: fixed priority, no fill
    logic         rsp_valid0, rsp_port0, init_done0, ceb0, web0;
    logic [7:0]   ram_a0;
    logic [127:0] rsp_rdata0, ram_d0, q0;
    logic [15:0]  bweb0;
    logic         rsp_valid1, rsp_port1, init_done1, ceb1, web1;
    logic [7:0]   ram_a1;
    logic [127:0] rsp_rdata1, ram_d1, q1;
    logic [15:0]  bweb1;

    spram_b16_arbiter #(.ARB_MODE(0), .INIT_EN(1)) dut0 (
        .clk(clk), .rst(rst), .p0(a0), .p1(a1),
        .rsp_valid(rsp_valid0), .rsp_port(rsp_port0), .rsp_rdata(rsp_rdata0),
        .init_done(init_done0), .ram_ceb(ceb0), .ram_web(web0), .ram_a(ram_a0),
        .ram_d(ram_d0), .ram_bweb(bweb0), .ram_q(q0));

    spram_b16_arbiter #(.ARB_MODE(1), .INIT_EN(0)) dut1 (
        .clk(clk), .rst(rst), .p0(b0), .p1(b1),
        .rsp_valid(rsp_valid1), .rsp_port(rsp_port1), .rsp_rdata(rsp_rdata1),
        .init_done(init_done1), .ram_ceb(ceb1), .ram_web(web1), .ram_a(ram_a1),
        .ram_d(ram_d1), .ram_bweb(bweb1), .ram_q(q1));

    // Behavioural SRAM models: BWEB bit 1 keeps the old byte.
    logic [127:0] mem0 [256];
    logic [127:0] mem1 [256];

    function automatic logic [127:0] keep_mask(input logic [15:0] bweb);
        logic [127:0] m;
        for (int b = 0; b < 16; b++) m[b*8 +: 8] = {8{bweb[b]}};
        return m;
    endfunction

    always @(posedge clk) begin
        if (!ceb0) begin
            if (!web0) mem0[ram_a0] <= (mem0[ram_a0] & keep_mask(bweb0)) | (ram_d0 & ~keep_mask(bweb0));
            else       q0 <= mem0[ram_a0];
        end
        if (!ceb1) begin
            if (!web1) mem1[ram_a1] <= (mem1[ram_a1] & keep_mask(bweb1)) | (ram_d1 & ~keep_mask(bweb1));
            else       q1 <= mem1[ram_a1];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called right at a negedge; samples each cycle until init_done rises.
    task automatic fill_count(output int n, output bit bad, output bit rdy_seen);
        n = 0; bad = 0; rdy_seen = 0;
        for (int c = 0; c < 400; c++) begin
            #1;
            if (init_done0) break;
            if (a0.req_ready || a1.req_ready) rdy_seen = 1;
            if (!ceb0 && !web0) begin
                if (ram_a0 !== n[7:0] || ram_d0 !== Z || bweb0 !== 16'h0) bad = 1;
                n++;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic v0, we0; logic [7:0] a0; logic [15:0] s0;
        logic v1, we1; logic [7:0] a1; logic [15:0] s1;
        logic r0, r1, ceb, web; logic [7:0] a; logic [15:0] bweb; logic dw;
        logic rspv, rport; logic [127:0] rdata;
        logic f0, f1;
    } vec_t;

    vec_t vt [15];

    initial begin
        int n;
        bit bad, rdy_seen;

        //          v0 we0 a0     s0        v1 we1 a1     s1        r0 r1 ceb web a      bweb      dw  rspv rport rdata  f0 f1
        vt[0]  = '{T, T, 8'h12, 16'h00FF, F, F, 8'h00, 16'h0000, T, F, F, F, 8'h12, 16'hFF00, T,  F, F, Z,  T, F};
        vt[1]  = '{F, F, 8'h00, 16'h0000, T, F, 8'h12, 16'h0000, F, T, F, T, 8'h12, 16'hFFFF, F,  F, F, Z,  F, T};
        vt[2]  = '{F, F, 8'h00, 16'h0000, F, F, 8'h00, 16'h0000, F, F, T, T, 8'h00, 16'h0000, F,  T, T, LO, F, F};
        vt[3]  = '{T, F, 8'h01, 16'h0000, T, F, 8'h02, 16'h0000, T, F, F, T, 8'h01, 16'hFFFF, F,  F, F, Z,  T, F};
        vt[4]  = '{T, F, 8'h01, 16'h0000, T, F, 8'h02, 16'h0000, F, T, F, T, 8'h02, 16'hFFFF, F,  T, F, Z,  T, F};
        vt[5]  = '{T, F, 8'h01, 16'h0000, T, F, 8'h02, 16'h0000, T, F, F, T, 8'h01, 16'hFFFF, F,  T, T, Z,  T, F};
        vt[6]  = '{T, F, 8'h01, 16'h0000, T, F, 8'h02, 16'h0000, F, T, F, T, 8'h02, 16'hFFFF, F,  T, F, Z,  T, F};
        vt[7]  = '{T, T, 8'h12, 16'h0000, T, F, 8'h12, 16'h0000, T, T, F, T, 8'h12, 16'hFFFF, F,  T, T, Z,  T, T};
        vt[8]  = '{F, F, 8'h00, 16'h0000, F, F, 8'h00, 16'h0000, F, F, T, T, 8'h00, 16'h0000, F,  T, T, LO, F, F};
        vt[9]  = '{T, T, 8'h12, 16'hFF00, T, T, 8'h12, 16'h0001, T, F, F, F, 8'h12, 16'h00FF, T,  F, F, Z,  T, F};
        vt[10] = '{F, F, 8'h00, 16'h0000, T, T, 8'h12, 16'h0001, F, T, F, F, 8'h12, 16'hFFFE, T,  F, F, Z,  F, T};
        vt[11] = '{T, F, 8'h12, 16'h0000, F, F, 8'h00, 16'h0000, T, F, F, T, 8'h12, 16'hFFFF, F,  F, F, Z,  T, F};
        vt[12] = '{F, F, 8'h00, 16'h0000, F, F, 8'h00, 16'h0000, F, F, T, T, 8'h00, 16'h0000, F,  T, F, W,  F, F};
        vt[13] = '{T, T, 8'h12, 16'hFFFF, T, F, 8'h12, 16'h0000, F, T, F, T, 8'h12, 16'hFFFF, F,  F, F, Z,  T, F};
        vt[14] = '{T, T, 8'h12, 16'hFFFF, F, F, 8'h00, 16'h0000, T, F, F, F, 8'h12, 16'h0000, T,  T, T, W,  T, F};

        // Reset with port 0 already requesting; nothing may be accepted during fill.
        rst = 1; v0 = 1; we0 = 0; ad0 = 8'h05;
        repeat (2) @(negedge clk);
        #1;
        chk("reset init_done", init_done0, 0);
        chk("reset rsp_valid", rsp_valid0, 0);
        chk("reset rsp_port", rsp_port0, 0);
        chk("reset ceb", ceb0, 1);
        chk("reset ready0", a0.req_ready, 0);
        chk("noinit init_done", init_done1, 1);
        rst = 0;
        fill_count(n, bad, rdy_seen);
        chk("fill count", n, 256);
        chk("fill addr/data", bad, 0);
        chk("fill ready held low", rdy_seen, 0);
        chk("fill init_done", init_done0, 1);
        chk("post-fill ready0", a0.req_ready, 1);

        // Reset in the middle of the fill restarts it at address 0.
        @(negedge clk);
        v0 = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (100) @(negedge clk);
        #1;
        chk("mid-fill addr", ram_a0, 100);
        rst = 1;
        @(negedge clk);
        rst = 0;
        fill_count(n, bad, rdy_seen);
        chk("refill count", n, 256);
        chk("refill addr/data", bad, 0);
        chk("refill init_done", init_done0, 1);

        // Directed vectors, one per cycle; response fields refer to the previous row.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            v0 = vt[i].v0; we0 = vt[i].we0; ad0 = vt[i].a0; st0 = vt[i].s0;
            v1 = vt[i].v1; we1 = vt[i].we1; ad1 = vt[i].a1; st1 = vt[i].s1;
            #1;
            chk($sformatf("row%0d ready0", i), a0.req_ready, vt[i].r0);
            chk($sformatf("row%0d ready1", i), a1.req_ready, vt[i].r1);
            chk($sformatf("row%0d ceb", i), ceb0, vt[i].ceb);
            chk($sformatf("row%0d web", i), web0, vt[i].web);
            chk($sformatf("row%0d addr", i), ram_a0, vt[i].a);
            chk($sformatf("row%0d bweb", i), bweb0, vt[i].bweb);
            chk($sformatf("row%0d d", i), ram_d0, vt[i].dw ? W : Z);
            chk($sformatf("row%0d rsp_valid", i), rsp_valid0, vt[i].rspv);
            if (vt[i].rspv) begin
                chk($sformatf("row%0d rsp_port", i), rsp_port0, vt[i].rport);
                chk($sformatf("row%0d rsp_rdata", i), rsp_rdata0, vt[i].rdata);
            end
            chk($sformatf("row%0d fixed ready0", i), b0.req_ready, vt[i].f0);
            chk($sformatf("row%0d fixed ready1", i), b1.req_ready, vt[i].f1);
        end

        // Read accepted, then reset in the response cycle: response is dropped.
        @(negedge clk);
        v0 = 1; we0 = 0; ad0 = 8'h12; st0 = 0; v1 = 0;
        #1;
        chk("drop accept", a0.req_ready, 1);
        @(negedge clk);
        v0 = 0; rst = 1;
        #1;
        chk("drop rsp_valid in rst", rsp_valid0, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("drop rsp_valid after", rsp_valid0, 0);
        chk("drop back to init", init_done0, 0);
        chk("drop fill restarts", {ceb0, web0, ram_a0}, {1'b0, 1'b0, 8'h00});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
